// File: rtl/cond_logic_if.sv
// cond_logic_if: decoder/ALU to conditional-execution stage bundle.
// The stage owns the NZCV register and returns gated strobes and Flags.
interface cond_logic_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       Stall;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
    input  PCSrc, RegWrite, MemWrite, Flags
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
    output PCSrc, RegWrite, MemWrite, Flags
  );
endinterface

// File: rtl/cond_logic.sv
// cond_logic: NZCV flag register and ARM condition-code evaluation.
// Gates decoder requests into PCSrc/RegWrite/MemWrite strobes.
module cond_logic (
  input  logic         clk,
  input  logic         reset,
  cond_logic_if.slave  bus
);

  logic [1:0] r_nz;
  logic [1:0] r_cv;
  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;
  logic       w_condex;
  logic       w_go;
  logic [1:0] w_flagwrite;

  assign w_n = r_nz[1];
  assign w_z = r_nz[0];
  assign w_c = r_cv[1];
  assign w_v = r_cv[0];

  // Evaluate the condition field against the registered (old) flags.
  always_comb begin
    w_condex = 1'b0;
    case (bus.Cond)
      4'b0000: w_condex = w_z;
      4'b0001: w_condex = ~w_z;
      4'b0010: w_condex = w_c;
      4'b0011: w_condex = ~w_c;
      4'b0100: w_condex = w_n;
      4'b0101: w_condex = ~w_n;
      4'b0110: w_condex = w_v;
      4'b0111: w_condex = ~w_v;
      4'b1000: w_condex = w_c & ~w_z;
      4'b1001: w_condex = ~w_c | w_z;
      4'b1010: w_condex = ~(w_n ^ w_v);
      4'b1011: w_condex = w_n ^ w_v;
      4'b1100: w_condex = ~w_z & ~(w_n ^ w_v);
      4'b1101: w_condex = w_z | (w_n ^ w_v);
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  assign w_go        = w_condex & ~bus.Stall & reset;
  assign w_flagwrite = bus.FlagW & {2{w_go}};

  assign bus.PCSrc    = bus.PCS & w_go;
  assign bus.RegWrite = bus.RegW & ~bus.NoWrite & w_go;
  assign bus.MemWrite = bus.MemW & w_go;
  assign bus.Flags    = {r_nz, r_cv};

  // Flag halves update independently; reset clears both and wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_nz <= 2'b00;
      r_cv <= 2'b00;
    end else begin
      if (w_flagwrite[1]) r_nz <= bus.ALUFlags[3:2];
      if (w_flagwrite[0]) r_cv <= bus.ALUFlags[1:0];
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: scoreboard bench for cond_logic.
// Expected strobes/flags queued per cycle from a reference model.
module tb_cond_logic;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  logic [3:0] m_flags;
  logic [6:0] sb_q[$];

  cond_logic_if bus ();

  cond_logic dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] f,
                                   input logic [3:0] c);
    logic n, z, cc, v, b;
    {n, z, cc, v} = f;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cc;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cc && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    if (c == 4'hf) return 1'b0;
    return b ^ c[0];
  endfunction

  task automatic step(input logic rst, input logic [3:0] cond,
                      input logic [3:0] alu, input logic [1:0] fw,
                      input logic pcs, input logic regw,
                      input logic memw, input logic nowr,
                      input logic stall);
    logic       go;
    logic [6:0] e;
    reset            = rst;
    bus.Cond         = cond;
    bus.ALUFlags     = alu;
    bus.FlagW        = fw;
    bus.PCS          = pcs;
    bus.RegW         = regw;
    bus.MemW         = memw;
    bus.NoWrite      = nowr;
    bus.Stall        = stall;
    go = cond_ok(m_flags, cond) && !stall && rst;
    sb_q.push_back({pcs & go, regw & ~nowr & go, memw & go, m_flags});
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
    end else begin
      e = sb_q.pop_front();
      chk("PCSrc", {7'd0, bus.PCSrc}, {7'd0, e[6]});
      chk("RegWrite", {7'd0, bus.RegWrite}, {7'd0, e[5]});
      chk("MemWrite", {7'd0, bus.MemWrite}, {7'd0, e[4]});
      chk("Flags", {4'd0, bus.Flags}, {4'd0, e[3:0]});
    end
    @(posedge clk);
    if (!rst) begin
      m_flags = 4'b0000;
    end else begin
      if (fw[1] && go) m_flags[3:2] = alu[3:2];
      if (fw[0] && go) m_flags[1:0] = alu[1:0];
    end
    #1;
  endtask

  task automatic load(input logic [3:0] f);
    step(1'b1, 4'he, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    m_flags = 4'b0000;
    reset        = 1'b0;
    bus.Cond     = 4'he;
    bus.ALUFlags = 4'hf;
    bus.FlagW    = 2'b11;
    bus.PCS      = 1'b1;
    bus.RegW     = 1'b1;
    bus.MemW     = 1'b1;
    bus.NoWrite  = 1'b0;
    bus.Stall    = 1'b0;
    @(posedge clk);
    #1;

    // reset held with aggressive requests
    step(1'b0, 4'he, 4'hf, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'he, 4'hf, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // CMP then BEQ / BNE
    step(1'b1, 4'he, 4'h4, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    load(4'h0);
    step(1'b1, 4'he, 4'h4, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'h1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // partial NZ update keeps CV
    load(4'h3);
    step(1'b1, 4'he, 4'h8, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'he, 4'h4, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // full condition sweep
    for (int f = 0; f < 16; f++) begin
      load(4'(f));
      for (int c = 0; c < 16; c++)
        step(1'b1, 4'(c), 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // failed conditional store with flag set
    load(4'h0);
    step(1'b1, 4'h0, 4'h6, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // own condition uses old Z
    load(4'h4);
    step(1'b1, 4'h0, 4'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h0, 4'h8, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // stall for three cycles
    load(4'h4);
    for (int k = 0; k < 3; k++)
      step(1'b1, 4'he, 4'h9, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'he, 4'h9, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset collides with a flag-setting CMP
    load(4'hf);
    step(1'b0, 4'he, 4'h4, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'h1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 19) != 0), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0));
    step(1'b1, 4'he, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    if (sb_q.size() != 0)
      chk("sb_leftover", 8'(sb_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
